// File: rtl/pipeline_buffer.sv
// pipeline_buffer: circular valid/ready buffer of DEPTH entries of WIDTH bits (any DEPTH, 2..16).
// Latency: 1 cycle from push to out_data; 0 cycles when PIPELINE_BUFFER_BYPASS_EN is defined and the buffer is empty.
// Backpressure: in_ready = (count < DEPTH) || out_ready, so a full buffer takes a push on the same edge as a pop.
module pipeline_buffer #(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Storage is not reset: only pointers and occupancy are architectural.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count_q;
  logic             not_empty;
  logic             bypass;
  logic             push;
  logic             pop;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q < CW'(DEPTH)) || out_ready;

`ifdef PIPELINE_BUFFER_BYPASS_EN
  // Empty buffer with a ready consumer: hand in_data straight through, store nothing.
  assign bypass = !rst && !not_empty && in_valid && out_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push  = in_valid && in_ready && !flush && !bypass;
  assign pop   = not_empty && out_ready && !flush;
  assign count = count_q;

  // Output mux: oldest entry when occupied, RST_VAL otherwise (or the bypassed input).
  always_comb begin
    out_valid = not_empty;
    out_data  = not_empty ? mem[head] : RST_VAL;
`ifdef PIPELINE_BUFFER_BYPASS_EN
    if (bypass) begin
      out_valid = 1'b1;
      out_data  = in_data;
    end
`endif
  end

  // Pointer and occupancy state; flush outranks push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry write at the tail; a full buffer only pushes while popping, so head is never overwritten early.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_data;
  end

endmodule

// File: tb/tb_pipeline_buffer.sv
// tb_pipeline_buffer: checks pipeline_buffer (DEPTH=2 and DEPTH=3 instances) against a queue model.
// Inputs change 1 time unit after each rising edge; outputs are compared on every falling edge.
// Honours PIPELINE_BUFFER_BYPASS_EN the same way the design does.
module tb_pipeline_buffer;

`ifdef PIPELINE_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  // DEPTH=2 instance
  logic       fl2, iv2, ir2, ov2, or2;
  logic [7:0] id2, od2;
  logic [1:0] cnt2;

  // DEPTH=3 instance
  logic       fl3, iv3, ir3, ov3, or3;
  logic [7:0] id3, od3;
  logic [1:0] cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q2 [$];
  logic [7:0] q3 [$];
  logic [7:0] log2 [$];
  logic [7:0] log3 [$];

  pipeline_buffer #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'hEE)) dut2 (
    .clk(clk), .rst(rst), .flush(fl2),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .count(cnt2)
  );

  pipeline_buffer #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) dut3 (
    .clk(clk), .rst(rst), .flush(fl3),
    .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .count(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue model: each edge applies flush, else pop-then-push with the same ready rule.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q2.delete();
      q3.delete();
    end else begin
      if (fl2) q2.delete();
      else begin
        if (!(BYP && q2.size() == 0 && iv2 && or2)) begin
          if (q2.size() != 0 && or2) void'(q2.pop_front());
          if (iv2 && (q2.size() < 2 || or2)) q2.push_back(id2);
        end
      end
      if (fl3) q3.delete();
      else begin
        if (!(BYP && q3.size() == 0 && iv3 && or3)) begin
          if (q3.size() != 0 && or3) void'(q3.pop_front());
          if (iv3 && (q3.size() < 3 || or3)) q3.push_back(id3);
        end
      end
    end
  end

  // Per-cycle compare against the model, plus a log of every value the consumer takes.
  always @(negedge clk) begin
    logic bp2, bp3;
    bp2 = BYP && !rst && !fl2 && q2.size() == 0 && iv2 && or2;
    bp3 = BYP && !rst && !fl3 && q3.size() == 0 && iv3 && or3;
    chk("out_valid2", 32'(ov2), 32'((q2.size() != 0) || bp2));
    chk("out_data2",  32'(od2), 32'(bp2 ? id2 : (q2.size() != 0 ? q2[0] : 8'hEE)));
    chk("in_ready2",  32'(ir2), 32'((q2.size() < 2) || or2));
    chk("count2",     32'(cnt2), 32'(q2.size()));
    chk("out_valid3", 32'(ov3), 32'((q3.size() != 0) || bp3));
    chk("out_data3",  32'(od3), 32'(bp3 ? id3 : (q3.size() != 0 ? q3[0] : 8'h00)));
    chk("in_ready3",  32'(ir3), 32'((q3.size() < 3) || or3));
    chk("count3",     32'(cnt3), 32'(q3.size()));
    if (!rst && !fl2 && ov2 && or2) log2.push_back(od2);
    if (!rst && !fl3 && ov3 && or3) log3.push_back(od3);
  end

  initial begin
    logic [7:0]  exp2 [5];
    logic [15:0] vp;
    logic [15:0] rp;
    int          nv;
    logic        acc;

    rst = 1'b1;
    fl2 = 0; iv2 = 0; or2 = 0; id2 = '0;
    fl3 = 0; iv3 = 0; or3 = 0; id3 = '0;

    // Reset state
    #1;
    chk("rst_count",     32'(cnt2), 32'd0);
    chk("rst_out_valid", 32'(ov2),  32'd0);
    chk("rst_out_data",  32'(od2),  32'hEE);
    chk("rst_in_ready",  32'(ir2),  32'd1);
    step();
    step();
    rst = 1'b0;

    // Stream 0x11, 0x22, 0x33 with the consumer always ready
    or2 = 1; iv2 = 1; id2 = 8'h11;
    if (BYP) begin
      #1;
      chk("byp_out_valid", 32'(ov2),  32'd1);
      chk("byp_out_data",  32'(od2),  32'h99 - 32'h88);
      chk("byp_count",     32'(cnt2), 32'd0);
      id2 = 8'h99;
      #1;
      chk("byp_out_data99", 32'(od2), 32'h99);
      id2 = 8'h11;
    end
    step();
    if (!BYP) begin
      chk("stream1_data", 32'(od2), 32'h11);
      chk("stream1_cnt",  32'(cnt2), 32'd1);
    end
    id2 = 8'h22;
    step();
    if (!BYP) chk("stream2_data", 32'(od2), 32'h22);
    id2 = 8'h33;
    step();
    if (!BYP) begin
      chk("stream3_data", 32'(od2), 32'h33);
      chk("stream3_cnt",  32'(cnt2), 32'd1);
    end
    iv2 = 0;
    step();

    // Backpressure, then push and pop on the same edge while full
    or2 = 0; iv2 = 1; id2 = 8'h0A;
    step();
    id2 = 8'h0B;
    step();
    chk("bp_count",    32'(cnt2), 32'd2);
    chk("bp_in_ready", 32'(ir2),  32'd0);
    chk("bp_hold",     32'(od2),  32'h0A);
    id2 = 8'h0C; or2 = 1;
    #1;
    chk("full_in_ready", 32'(ir2), 32'd1);
    step();
    chk("pp_count", 32'(cnt2), 32'd2);
    chk("pp_data",  32'(od2),  32'h0B);
    iv2 = 0; or2 = 0;
    step();

    // Flush with a concurrent push and pop
    fl2 = 1; iv2 = 1; id2 = 8'h55; or2 = 1;
    step();
    fl2 = 0; iv2 = 0; or2 = 0;
    chk("flush_count", 32'(cnt2), 32'd0);
    chk("flush_valid", 32'(ov2),  32'd0);
    chk("flush_data",  32'(od2),  32'hEE);
    step();

    // Asynchronous reset between edges with two entries held
    iv2 = 1; id2 = 8'h01;
    step();
    id2 = 8'h02;
    step();
    iv2 = 0;
    chk("pre_rst_count", 32'(cnt2), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count",    32'(cnt2), 32'd0);
    chk("arst_valid",    32'(ov2),  32'd0);
    chk("arst_data",     32'(od2),  32'hEE);
    chk("arst_in_ready", 32'(ir2),  32'd1);
    step();
    step();
    rst = 1'b0;
    iv2 = 1; id2 = 8'h07;
    step();
    iv2 = 0;
    chk("post_rst_valid", 32'(ov2),  32'd1);
    chk("post_rst_data",  32'(od2),  32'h07);
    chk("post_rst_count", 32'(cnt2), 32'd1);
    or2 = 1;
    step();
    or2 = 0;

    // DEPTH=3: values 1..10 at mixed rates so both pointers wrap several times
    vp = 16'b1110_1101_1011_1111;
    rp = 16'b0011_0101_1001_1000;
    nv = 1;
    for (int i = 0; i < 60 && !(nv > 10 && q3.size() == 0); i++) begin
      iv3 = (nv <= 10) && vp[i % 16];
      or3 = rp[i % 16] || (nv > 10);
      id3 = 8'(nv);
      acc = iv3 && ((q3.size() < 3) || or3);
      step();
      if (acc) nv++;
    end
    iv3 = 0; or3 = 0;
    step();

    exp2[0] = 8'h11; exp2[1] = 8'h22; exp2[2] = 8'h33; exp2[3] = 8'h0A; exp2[4] = 8'h07;
    chk("log2_len", 32'(log2.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < log2.size()) chk("log2_order", 32'(log2[i]), 32'(exp2[i]));
    chk("log3_len", 32'(log3.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < log3.size()) chk("log3_order", 32'(log3[i]), 32'(i + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
